bus_cycle_ctrl: RTL and testbench

// Executes 8085 machine cycles on the external pins: takes address from register-file ADDRESS, write byte

---
 rtl/bus_cycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// bus_cycle_ctrl : runs 8085 machine cycles (T1-T2-TW*-T3[-T4]) on the pins
// Revision 1.0
// ============================================================================
module bus_cycle_ctrl #(
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        timeout,
  input  logic        ready,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [7:0]  a_hi,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n,
  output logic        io_m,
  output logic        s1,
  output logic        s0
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_WAIT);

  localparam logic [2:0] c_opfetch = 3'd0;
  localparam logic [2:0] c_mem_rd  = 3'd1;
  localparam logic [2:0] c_mem_wr  = 3'd2;
  localparam logic [2:0] c_io_rd   = 3'd3;
  localparam logic [2:0] c_io_wr   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  state_t           r_state;
  logic [2:0]       r_type;
  logic [7:0]       r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_to_armed;

  logic       w_accept;
  logic       w_cur_fetch;
  logic       w_cur_read;
  logic       w_new_io;
  logic       w_wait_expired;
  logic [2:0] w_new_status;

  assign w_accept       = req && req_ready && (req_type <= c_io_wr);
  assign w_cur_fetch    = (r_type == c_opfetch);
  assign w_cur_read     = w_cur_fetch || (r_type == c_mem_rd) || (r_type == c_io_rd);
  assign w_new_io       = (req_type == c_io_rd) || (req_type == c_io_wr);
  assign w_wait_expired = (MAX_WAIT > 0) && (r_cnt == c_max_cnt);

  // {io_m, s1, s0} for the cycle being launched
  always_comb begin
    w_new_status = 3'b000;
    case (req_type)
      c_opfetch: w_new_status = 3'b011;
      c_mem_rd:  w_new_status = 3'b010;
      c_mem_wr:  w_new_status = 3'b001;
      c_io_rd:   w_new_status = 3'b110;
      c_io_wr:   w_new_status = 3'b101;
      default:   w_new_status = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_type     <= 3'd0;
      r_wdata    <= 8'h00;
      r_cnt      <= '0;
      r_to_armed <= 1'b0;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      timeout    <= 1'b0;
      rdata      <= 8'h00;
      ad_out     <= 8'h00;
      ad_oe      <= 1'b0;
      a_hi       <= 8'h00;
      ale        <= 1'b0;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      {io_m, s1, s0} <= 3'b000;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (r_state)
        S_T1: begin
          r_state <= S_T2;
          ale     <= 1'b0;
          if (w_cur_read) begin
            rd_n  <= 1'b0;
            ad_oe <= 1'b0;
          end else begin
            wr_n   <= 1'b0;
            ad_oe  <= 1'b1;
            ad_out <= r_wdata;
          end
        end
        S_T2: begin
          if (ready) begin
            r_state   <= S_T3;
            req_ready <= !w_cur_fetch;
          end else begin
            r_state <= S_TW;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        S_TW: begin
          if (ready || w_wait_expired) begin
            r_state    <= S_T3;
            req_ready  <= !w_cur_fetch;
            r_to_armed <= !ready;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_T3: begin
          if (w_cur_read) rdata <= ad_in;
          done    <= 1'b1;
          timeout <= r_to_armed;
          rd_n    <= 1'b1;
          wr_n    <= 1'b1;
          ad_oe   <= 1'b0;
          if (w_cur_fetch) begin
            r_state   <= S_T4;
            req_ready <= 1'b1;
          end
        end
        default: ;
      endcase

      // Final states (IDLE, non-fetch T3, T4) either launch the next cycle or go idle;
      // these assignments deliberately override the T3 bus release above.
      if (req_ready) begin
        if (w_accept) begin
          r_state    <= S_T1;
          r_type     <= req_type;
          r_wdata    <= req_wdata;
          r_cnt      <= '0;
          r_to_armed <= 1'b0;
          req_ready  <= 1'b0;
          ale        <= 1'b1;
          ad_oe      <= 1'b1;
          ad_out     <= req_addr[7:0];
          a_hi       <= w_new_io ? req_addr[7:0] : req_addr[15:8];
          {io_m, s1, s0} <= w_new_status;
        end else begin
          r_state        <= S_IDLE;
          {io_m, s1, s0} <= 3'b000;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
`default_nettype none
// Directed bench for bus_cycle_ctrl: one unlimited-wait instance and one with
// MAX_WAIT=3 sharing the same stimulus.
module tb_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  req_type;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ready;
  logic [7:0]  ad_in;

  logic       req_ready, done, timeout, ad_oe, ale, rd_n, wr_n, io_m, s1, s0;
  logic [7:0] rdata, ad_out, a_hi;

  logic       d3_req_ready, d3_done, d3_timeout, d3_ad_oe, d3_ale, d3_rd_n, d3_wr_n;
  logic       d3_io_m, d3_s1, d3_s0;
  logic [7:0] d3_rdata, d3_ad_out, d3_a_hi;

  // {req_ready, done, timeout, ale, rd_n, wr_n, ad_oe, io_m, s1, s0}
  logic [9:0] ctl;
  assign ctl = {req_ready, done, timeout, ale, rd_n, wr_n, ad_oe, io_m, s1, s0};

  bus_cycle_ctrl #(.MAX_WAIT(0)) dut (
    .clk(clk), .rst(rst), .req(req), .req_type(req_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .done(done), .rdata(rdata),
    .timeout(timeout), .ready(ready), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .a_hi(a_hi), .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .io_m(io_m), .s1(s1), .s0(s0)
  );

  bus_cycle_ctrl #(.MAX_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .req_type(req_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(d3_req_ready), .done(d3_done), .rdata(d3_rdata),
    .timeout(d3_timeout), .ready(ready), .ad_in(ad_in), .ad_out(d3_ad_out), .ad_oe(d3_ad_oe),
    .a_hi(d3_a_hi), .ale(d3_ale), .rd_n(d3_rd_n), .wr_n(d3_wr_n), .io_m(d3_io_m),
    .s1(d3_s1), .s0(d3_s0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rdy;
    logic [7:0]  din;
    logic [9:0]  ctl;
    logic [7:0]  aout;
    logic [7:0]  ahi;
    logic [7:0]  rdat;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  localparam logic [9:0] IDLE_CTL = 10'b1000110000;

  initial begin
    int  cyc;
    logic got, seen0;

    // opcode fetch 1234, ad_in 43
    tbl[0]  = '{1'b1, 3'd0, 16'h1234, 8'h00, 1'b1, 8'h43, 10'b0001111011, 8'h34, 8'h12, 8'h00};
    tbl[1]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h43, 10'b0000010011, 8'h00, 8'h12, 8'h00};
    tbl[2]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h43, 10'b0000010011, 8'h00, 8'h12, 8'h00};
    tbl[3]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h43, 10'b1100110011, 8'h00, 8'h12, 8'h43};
    tbl[4]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00, IDLE_CTL,       8'h00, 8'h12, 8'h43};
    // memory write BEEF <- 5A, two wait states
    tbl[5]  = '{1'b1, 3'd2, 16'hBEEF, 8'h5A, 1'b1, 8'h00, 10'b0001111001, 8'hEF, 8'hBE, 8'h43};
    tbl[6]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, 8'h00, 10'b0000101001, 8'h5A, 8'hBE, 8'h43};
    tbl[7]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, 8'h00, 10'b0000101001, 8'h5A, 8'hBE, 8'h43};
    tbl[8]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, 8'h00, 10'b0000101001, 8'h5A, 8'hBE, 8'h43};
    tbl[9]  = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 10'b1000101001, 8'h5A, 8'hBE, 8'h43};
    tbl[10] = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 10'b1100110000, 8'h00, 8'hBE, 8'h43};
    tbl[11] = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00, IDLE_CTL,       8'h00, 8'hBE, 8'h43};
    // invalid type 6 is ignored
    tbl[12] = '{1'b1, 3'd6, 16'h5555, 8'h11, 1'b1, 8'h00, IDLE_CTL,       8'h00, 8'hBE, 8'h43};
    tbl[13] = '{1'b1, 3'd6, 16'h5555, 8'h11, 1'b1, 8'h00, IDLE_CTL,       8'h00, 8'hBE, 8'h43};
    // back-to-back io read 20 then memory read 0100
    tbl[14] = '{1'b1, 3'd3, 16'h0020, 8'h00, 1'b1, 8'h00, 10'b0001111110, 8'h20, 8'h20, 8'h43};
    tbl[15] = '{1'b1, 3'd1, 16'h0100, 8'h00, 1'b1, 8'h00, 10'b0000010110, 8'h00, 8'h20, 8'h43};
    tbl[16] = '{1'b1, 3'd1, 16'h0100, 8'h00, 1'b1, 8'h00, 10'b1000010110, 8'h00, 8'h20, 8'h43};
    tbl[17] = '{1'b1, 3'd1, 16'h0100, 8'h00, 1'b1, 8'hA7, 10'b0101111010, 8'h00, 8'h01, 8'hA7};
    tbl[18] = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 10'b0000010010, 8'h00, 8'h01, 8'hA7};
    tbl[19] = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 10'b1000010010, 8'h00, 8'h01, 8'hA7};
    tbl[20] = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h3C, 10'b1100110000, 8'h00, 8'h01, 8'h3C};
    tbl[21] = '{1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 8'h00, IDLE_CTL,       8'h00, 8'h01, 8'h3C};

    rst = 1'b1; req = 1'b0; req_type = 3'd0; req_addr = 16'h0; req_wdata = 8'h0;
    ready = 1'b1; ad_in = 8'h00;
    #2 rst = 1'b0;
    #10;
    check("reset ctl", 32'(ctl), 32'(IDLE_CTL));
    check("reset rdata", 32'(rdata), 32'h0);
    check("reset a_hi", 32'(a_hi), 32'h0);
    check("reset ad_out", 32'(ad_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      req = tbl[i].req; req_type = tbl[i].typ; req_addr = tbl[i].addr;
      req_wdata = tbl[i].wdata; ready = tbl[i].rdy; ad_in = tbl[i].din;
      @(posedge clk); #1;
      check($sformatf("vec%0d ctl", i), 32'(ctl), 32'(tbl[i].ctl));
      check($sformatf("vec%0d a_hi", i), 32'(a_hi), 32'(tbl[i].ahi));
      check($sformatf("vec%0d rdata", i), 32'(rdata), 32'(tbl[i].rdat));
      if (tbl[i].ctl[3]) check($sformatf("vec%0d ad_out", i), 32'(ad_out), 32'(tbl[i].aout));
      @(negedge clk);
    end

    // MAX_WAIT=3 forces T3 after three waits; unlimited instance keeps waiting
    req = 1'b1; req_type = 3'd1; req_addr = 16'h0400; ready = 1'b0; ad_in = 8'h99;
    @(posedge clk); #1;
    req = 1'b0;
    cyc = 1; got = 1'b0; seen0 = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (d3_done) got = 1'b1;
      if (done) seen0 = 1'b1;
    end
    check("mw3 done latency", 32'(cyc), 32'd7);
    check("mw3 timeout", 32'(d3_timeout), 32'd1);
    check("mw3 rdata", 32'(d3_rdata), 32'h99);
    check("mw0 no done", 32'(seen0), 32'd0);
    check("mw0 still in wait rd_n", 32'(rd_n), 32'd0);
    @(posedge clk); #1;
    check("mw3 pulses cleared", 32'({d3_done, d3_timeout}), 32'd0);
    check("mw0 no timeout", 32'(timeout), 32'd0);

    // async reset during a wait state of an io write
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort read ctl", 32'(ctl), 32'(IDLE_CTL));
    @(negedge clk);
    rst = 1'b1;
    req = 1'b1; req_type = 3'd4; req_addr = 16'h3377; req_wdata = 8'hC3; ready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    check("iowr T1 ctl", 32'(ctl), 32'b0001111101);
    check("iowr T1 a_hi dup", 32'(a_hi), 32'h77);
    @(posedge clk); #1;
    check("iowr T2 ctl", 32'(ctl), 32'b0000101101);
    check("iowr T2 ad_out", 32'(ad_out), 32'hC3);
    @(posedge clk); #1;
    check("iowr TW ctl", 32'(ctl), 32'b0000101101);
    #2 rst = 1'b0;
    #1;
    check("async reset ctl", 32'(ctl), 32'(IDLE_CTL));
    check("async reset a_hi", 32'(a_hi), 32'h0);
    @(negedge clk);
    rst = 1'b1; ready = 1'b1;
    seen0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done || d3_done) seen0 = 1'b1;
    end
    check("post reset no done", 32'(seen0), 32'd0);
    check("post reset idle", 32'(ctl), 32'(IDLE_CTL));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
